hazard_scheduler: RTL
=====================

// Module: hazard_scheduler
// PURPOSE
//  Pipeline-control scheduler between decode and the ID/EX register of the 4-bit-regfile CPU.
//  Tracks in-flight register writes in a per-register countdown scoreboard and sequences branch/JAL resolution.
//  Drives fetch stall, ID/EX bubble and IF/ID flush.
//  Keeps a saturating bubble counter for performance debug.
// PARAMETERS
//  ALU_LAT   3   cycles from issue until an ALU/JAL result is readable from the regfile
//  LOAD_LAT  4   cycles from issue until a load result is readable (LOAD_LAT >= ALU_LAT)
//  CNT_W     16  width of bubble_count
// PORTS
//  clk          in   1      single clock; all state updates on posedge
//  rst_n        in   1      synchronous, active-low reset
//  dec_valid    in   1      decode holds a real instruction
//  s1Addr       in   4      source-1 register
//  s2Addr       in   4      source-2 register
//  s1used       in   1      source 1 is read
//  s2used       in   1      source 2 is read
//  dAddr        in   4      destination register
//  regWrtEn     in   1      instruction writes dAddr
//  isLoad       in   1      instruction is a load
//  isBranch     in   1      instruction is a conditional branch
//  isJAL        in   1      instruction is JAL
//  ex_resolve   in   1      execute stage resolves the pending branch/JAL this cycle
//  ex_taken     in   1      branch outcome (cmpIn); ignored for JAL (always taken)
//  stall        out  1      hold PC and IF/ID
//  bubble       out  1      inject NOP into ID/EX (decode instruction not issued)
//  flush        out  1      squash IF/ID contents
//  issue        out  1      decode instruction is accepted into ID/EX this cycle
//  bubble_count out  CNT_W  saturating count of bubble cycles since reset
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=RUN, all scoreboard counters=0, pend_jal=0, bubble_count=0.
//  While rst_n=0: stall, bubble, flush and issue are forced to 0.
//  Scoreboard: pend[r] is a 3-bit counter per register r in 0..15.
//  - Every cycle each nonzero pend[r] decrements by 1; counters saturate at 0.
//  - On issue with regWrtEn=1: pend[dAddr] <= isLoad ? LOAD_LAT : ALU_LAT.
//  - Issue load overrides the decrement of the same register in the same cycle.
//  Hazard (combinational) = (s1used & pend[s1Addr]!=0) | (s2used & pend[s2Addr]!=0).
//  Outputs are combinational from registered state and current decode inputs (zero-cycle latency).
//  FSM states:
//  - RUN:
//    - dec_valid & hazard: stall=1, bubble=1, issue=0; stay RUN.
//    - dec_valid & !hazard: issue=1.
//      - If isBranch|isJAL: go to WAIT_BR and latch pend_jal=isJAL.
//    - !dec_valid: no outputs asserted.
//  - WAIT_BR:
//    - stall=1, bubble=1 each cycle, issue=0.
//    - ex_resolve & (ex_taken | pend_jal): go to FLUSH.
//    - ex_resolve & !taken: go to RUN.
//  - FLUSH: exactly one cycle; flush=1, bubble=1, stall=0 (PC loads target); then go to RUN.
//  Simultaneous events:
//  - Hazard and branch on the same decode instruction: hazard wins, no issue.
//  - ex_resolve outside WAIT_BR is ignored.
//  Reset mid-WAIT_BR or mid-FLUSH: returns to RUN next cycle; in-flight branch is abandoned.
//  bubble_count increments on every cycle with bubble=1 and holds at all-ones.
// STRUCTURE
//  Shared package hazard_pkg:
//  - state enum {RUN, WAIT_BR, FLUSH}.
//  - ALU_LAT and LOAD_LAT defaults.
//  - REG_AW=4.
//  Sub-module reg_scoreboard (16 x 3-bit countdown).
//  - Ports: clk, rst_n, set_en, set_addr, set_val, rd1/rd2 addr, busy1/busy2.
//  FSM, output decode and bubble counter live in the top.
// TESTING
//  1. Issue ADD r3 (ALU) then SUB reading r3 -> 3 bubble cycles, issue on the 4th cycle; bubble_count=3.
//  2. LOAD r5 then ADD reading r5 as s2 -> 4 bubble cycles; with s2used=0 -> no bubble.
//  3. BEQ issued, ex_resolve=1 ex_taken=1 two cycles later -> 2 stall cycles, 1 flush cycle, then RUN.
//  4. BEQ not taken -> stall until ex_resolve, flush never asserted; JAL with ex_taken=0 -> flush=1.
//  5. rst_n=0 during WAIT_BR -> outputs 0 that cycle; next cycle RUN, scoreboard clear, bubble_count=0.
//  6. Hold bubble for 2^CNT_W+5 cycles -> bubble_count saturates at 16'hFFFF.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and defaults for the decode/ID-EX hazard scheduler.
package hazard_pkg;

    localparam int unsigned RegAw      = 4;
    localparam int unsigned NumRegs    = 1 << RegAw;
    localparam int unsigned PendW      = 3;
    localparam int unsigned DefAluLat  = 3;
    localparam int unsigned DefLoadLat = 4;
    localparam int unsigned DefCntW    = 16;

    typedef enum logic [1:0] {
        StRun,
        StWaitBr,
        StFlush
    } state_e;

endpackage

// File: rtl/hazard_if.sv
// Decode/execute-side signals into the scheduler and its pipeline-control outputs.
interface hazard_if
    import hazard_pkg::*;
#(
    parameter int unsigned CNT_W = DefCntW
);
    logic             dec_valid;
    logic [RegAw-1:0] s1Addr;
    logic [RegAw-1:0] s2Addr;
    logic             s1used;
    logic             s2used;
    logic [RegAw-1:0] dAddr;
    logic             regWrtEn;
    logic             isLoad;
    logic             isBranch;
    logic             isJAL;
    logic             ex_resolve;
    logic             ex_taken;
    logic             stall;
    logic             bubble;
    logic             flush;
    logic             issue;
    logic [CNT_W-1:0] bubble_count;

    modport master (
        output dec_valid, s1Addr, s2Addr, s1used, s2used, dAddr, regWrtEn,
               isLoad, isBranch, isJAL, ex_resolve, ex_taken,
        input  stall, bubble, flush, issue, bubble_count
    );

    modport slave (
        input  dec_valid, s1Addr, s2Addr, s1used, s2used, dAddr, regWrtEn,
               isLoad, isBranch, isJAL, ex_resolve, ex_taken,
        output stall, bubble, flush, issue, bubble_count
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register countdown of cycles until an in-flight write becomes readable.
module reg_scoreboard
    import hazard_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_en,
    input  logic [RegAw-1:0] set_addr,
    input  logic [PendW-1:0] set_val,
    input  logic [RegAw-1:0] rd1_addr,
    input  logic [RegAw-1:0] rd2_addr,
    output logic             busy1,
    output logic             busy2
);
    logic [PendW-1:0] pend_q [NumRegs];
    logic [PendW-1:0] pend_d [NumRegs];

    // Decrement every nonzero counter; a new issue overrides its own register.
    always_comb begin
        for (int r = 0; r < int'(NumRegs); r++) begin
            pend_d[r] = (pend_q[r] != '0) ? pend_q[r] - PendW'(1) : '0;
        end
        if (set_en) begin
            pend_d[set_addr] = set_val;
        end
    end

    // Counter state with synchronous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q <= '{default: '0};
        end else begin
            pend_q <= pend_d;
        end
    end

    assign busy1 = (pend_q[rd1_addr] != '0);
    assign busy2 = (pend_q[rd2_addr] != '0);
endmodule

// File: rtl/hazard_scheduler.sv
// Stall/bubble/flush control between decode and ID/EX, with a bubble perf counter.
module hazard_scheduler
    import hazard_pkg::*;
#(
    parameter int unsigned ALU_LAT  = DefAluLat,
    parameter int unsigned LOAD_LAT = DefLoadLat,
    parameter int unsigned CNT_W    = DefCntW
) (
    input  logic     clk,
    input  logic     rst_n,
    hazard_if.slave  sched_if
);
    state_e           state_q, state_d;
    logic             pend_jal_q, pend_jal_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             busy1, busy2, hazard;
    logic             stall, bubble, flush, issue;
    logic             set_en;
    logic [PendW-1:0] set_val;

    assign set_en  = issue & sched_if.regWrtEn;
    assign set_val = sched_if.isLoad ? PendW'(LOAD_LAT) : PendW'(ALU_LAT);

    reg_scoreboard u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (set_en),
        .set_addr (sched_if.dAddr),
        .set_val  (set_val),
        .rd1_addr (sched_if.s1Addr),
        .rd2_addr (sched_if.s2Addr),
        .busy1    (busy1),
        .busy2    (busy2)
    );

    assign hazard = (sched_if.s1used & busy1) | (sched_if.s2used & busy2);

    // Next state and pipeline-control outputs; everything forced low during reset.
    always_comb begin
        state_d    = state_q;
        pend_jal_d = pend_jal_q;
        stall      = 1'b0;
        bubble     = 1'b0;
        flush      = 1'b0;
        issue      = 1'b0;
        unique case (state_q)
            StRun: begin
                if (sched_if.dec_valid) begin
                    if (hazard) begin
                        stall  = 1'b1;
                        bubble = 1'b1;
                    end else begin
                        issue = 1'b1;
                        if (sched_if.isBranch | sched_if.isJAL) begin
                            state_d    = StWaitBr;
                            pend_jal_d = sched_if.isJAL;
                        end
                    end
                end
            end
            StWaitBr: begin
                stall  = 1'b1;
                bubble = 1'b1;
                if (sched_if.ex_resolve) begin
                    state_d = (sched_if.ex_taken | pend_jal_q) ? StFlush : StRun;
                end
            end
            StFlush: begin
                // PC loads the target this cycle, so no stall.
                flush   = 1'b1;
                bubble  = 1'b1;
                state_d = StRun;
            end
            default: state_d = StRun;
        endcase
        if (!rst_n) begin
            stall  = 1'b0;
            bubble = 1'b0;
            flush  = 1'b0;
            issue  = 1'b0;
        end
    end

    // Saturating bubble counter.
    always_comb begin
        count_d = count_q;
        if (bubble && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // FSM and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StRun;
            pend_jal_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pend_jal_q <= pend_jal_d;
            count_q    <= count_d;
        end
    end

    assign sched_if.stall        = stall;
    assign sched_if.bubble       = bubble;
    assign sched_if.flush        = flush;
    assign sched_if.issue        = issue;
    assign sched_if.bubble_count = count_q;
endmodule
